// File: rtl/fdivsqrt_iter_regs.sv
// Iteration sequencer and state registers around the radix-4 divide/sqrt
// recurrence stage. Loads the initial residual/root/thermometer values,
// feeds the stage each cycle with j1/jlast and divisor multiples, captures
// the stage outputs and hands the result to postprocessing via valid/ready.
// Optional macro FDIVSQRT_ZERO_EXIT_EN: finish early once the residual
// becomes exactly zero and flag it on EarlyExit.
module fdivsqrt_iter_regs #(
  parameter int unsigned DIVB  = 64,
  parameter int unsigned ITERW = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Kill,
  input  logic             SqrtIn,
  input  logic [ITERW-1:0] NumIter,
  input  logic [DIVB+3:0]  WSInit,
  input  logic [DIVB+3:0]  DIn,
  input  logic [DIVB:0]    UInit,
  input  logic [DIVB:0]    UMInit,
  input  logic [DIVB+1:0]  CInit,
  input  logic [DIVB+3:0]  WSNext,
  input  logic [DIVB+3:0]  WCNext,
  input  logic [DIVB:0]    UNext,
  input  logic [DIVB:0]    UMNext,
  input  logic [DIVB+1:0]  CNext,
  output logic [DIVB+3:0]  WS,
  output logic [DIVB+3:0]  WC,
  output logic [DIVB:0]    U,
  output logic [DIVB:0]    UM,
  output logic [DIVB+1:0]  C,
  output logic [DIVB+3:0]  D,
  output logic [DIVB+3:0]  DBar,
  output logic [DIVB+3:0]  D2,
  output logic [DIVB+3:0]  DBar2,
  output logic             SqrtE,
  output logic             j1,
  output logic             jlast,
  output logic             Busy,
  output logic             ResultValid,
  input  logic             ResultReady,
  output logic             EarlyExit
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

  state_t           state_q;
  logic [DIVB+3:0]  ws_q, wc_q, d_q;
  logic [DIVB:0]    u_q, um_q;
  logic [DIVB+1:0]  c_q;
  logic [ITERW-1:0] cnt_q, last_idx_q;
  logic [ITERW-1:0] last_idx_d;
  logic             sqrt_q;

  // NumIter of 0 runs a single iteration like NumIter of 1
  assign last_idx_d = (NumIter == '0) ? '0 : NumIter - ITERW'(1);

`ifdef FDIVSQRT_ZERO_EXIT_EN
  logic early_q;
  logic zero_next;

  assign zero_next = (WSNext == '0) && (WCNext == '0);
  assign EarlyExit = early_q;
`else
  assign EarlyExit = 1'b0;
`endif

  // Sequencer FSM plus all datapath state; Kill has top priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ws_q       <= '0;
      wc_q       <= '0;
      u_q        <= '0;
      um_q       <= '0;
      c_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
      sqrt_q     <= 1'b0;
`ifdef FDIVSQRT_ZERO_EXIT_EN
      early_q    <= 1'b0;
`endif
    end else if (Kill) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            ws_q       <= WSInit;
            wc_q       <= '0;
            u_q        <= UInit;
            um_q       <= UMInit;
            c_q        <= CInit;
            d_q        <= DIn;
            sqrt_q     <= SqrtIn;
            cnt_q      <= '0;
            last_idx_q <= last_idx_d;
`ifdef FDIVSQRT_ZERO_EXIT_EN
            early_q    <= 1'b0;
`endif
            state_q    <= StIter;
          end
        end
        StIter: begin
          ws_q <= WSNext;
          wc_q <= WCNext;
          u_q  <= UNext;
          um_q <= UMNext;
          c_q  <= CNext;
          if (jlast) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + ITERW'(1);
`ifdef FDIVSQRT_ZERO_EXIT_EN
            // Remaining digits would all be zero, so the root is already final
            if (zero_next) begin
              state_q <= StDone;
              early_q <= 1'b1;
            end
`endif
          end
        end
        StDone: begin
          if (ResultReady) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Iteration flags and status decoded from registered state
  always_comb begin
    Busy        = (state_q == StIter);
    ResultValid = (state_q == StDone);
    j1          = Busy && (cnt_q == '0);
    jlast       = Busy && (cnt_q == last_idx_q);
  end

  // Divisor multiples; the MSB shifted out of D2 is dropped
  always_comb begin
    D     = d_q;
    DBar  = ~d_q;
    D2    = {d_q[DIVB+2:0], 1'b0};
    DBar2 = ~{d_q[DIVB+2:0], 1'b0};
  end

  assign WS    = ws_q;
  assign WC    = wc_q;
  assign U     = u_q;
  assign UM    = um_q;
  assign C     = c_q;
  assign SqrtE = sqrt_q;

endmodule

// File: tb/tb_fdivsqrt_iter_regs.sv
// Self-checking bench for fdivsqrt_iter_regs. The recurrence stage is modelled
// by constant Next values; expected results are queued at Start and compared
// when ResultValid is seen.
module tb_fdivsqrt_iter_regs;
  localparam int DIVB  = 64;
  localparam int ITERW = 6;

  typedef struct packed {
    logic [DIVB+3:0] ws;
    logic [DIVB+3:0] wc;
    logic [DIVB:0]   u;
    logic [DIVB:0]   um;
    logic [DIVB+1:0] c;
  } res_t;

  logic             clk = 1'b0;
  logic             reset, Start, Kill, SqrtIn, ResultReady;
  logic [ITERW-1:0] NumIter;
  logic [DIVB+3:0]  WSInit, DIn, WSNext, WCNext;
  logic [DIVB:0]    UInit, UMInit, UNext, UMNext;
  logic [DIVB+1:0]  CInit, CNext;
  logic [DIVB+3:0]  WS, WC, D, DBar, D2, DBar2;
  logic [DIVB:0]    U, UM;
  logic [DIVB+1:0]  C;
  logic             SqrtE, j1, jlast, Busy, ResultValid, EarlyExit;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;

  fdivsqrt_iter_regs #(.DIVB(DIVB), .ITERW(ITERW)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Kill(Kill), .SqrtIn(SqrtIn),
    .NumIter(NumIter), .WSInit(WSInit), .DIn(DIn), .UInit(UInit), .UMInit(UMInit),
    .CInit(CInit), .WSNext(WSNext), .WCNext(WCNext), .UNext(UNext), .UMNext(UMNext),
    .CNext(CNext), .WS(WS), .WC(WC), .U(U), .UM(UM), .C(C), .D(D), .DBar(DBar),
    .D2(D2), .DBar2(DBar2), .SqrtE(SqrtE), .j1(j1), .jlast(jlast), .Busy(Busy),
    .ResultValid(ResultValid), .ResultReady(ResultReady), .EarlyExit(EarlyExit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic res_t rnd_res();
    logic [95:0] t;
    res_t r;
    t = {$urandom, $urandom, $urandom}; r.ws = t[DIVB+3:0];
    t = {$urandom, $urandom, $urandom}; r.wc = t[DIVB+3:0];
    t = {$urandom, $urandom, $urandom}; r.u  = t[DIVB:0];
    t = {$urandom, $urandom, $urandom}; r.um = t[DIVB:0];
    t = {$urandom, $urandom, $urandom}; r.c  = t[DIVB+1:0];
    r.ws[0] = 1'b1;  // keep the residual nonzero
    return r;
  endfunction

  function automatic res_t dut_res();
    return {WS, WC, U, UM, C};
  endfunction

  // Drive one Start cycle; leaves the bench in cycle 1 of the operation
  task automatic start_op(input logic [ITERW-1:0] n, input logic sq,
                          input logic [DIVB+3:0] din, input res_t nxt, input res_t exp);
    res_t ini;
    ini = rnd_res();
    WSInit = ini.ws; UInit = ini.u; UMInit = ini.um; CInit = ini.c;
    DIn = din; SqrtIn = sq; NumIter = n;
    {WSNext, WCNext, UNext, UMNext, CNext} = nxt;
    Start = 1'b1;
    sb_q.push_back(exp);
    start_cyc = cyc;
    tick();
    Start = 1'b0;
  endtask

  // Bounded wait for ResultValid; lat = cycles since Start, -1 on timeout
  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (ResultValid) begin
        lat = cyc - start_cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic accept();
    ResultReady = 1'b1;
    tick();
    ResultReady = 1'b0;
  endtask

  task automatic test_reset();
    res_t nxt, exp;
    int   lat;
    reset = 1'b0;
    #12;
    n_checks++;
    if ({WS, WC, U, UM, C, D, SqrtE, j1, jlast, Busy, ResultValid, EarlyExit} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got %h want 0",
               {WS, WC, U, UM, C, D, SqrtE, j1, jlast, Busy, ResultValid, EarlyExit});
    end
    reset = 1'b1;
    tick();
    // reset asserted asynchronously in cycle 3 of an 8-iteration run
    nxt = rnd_res();
    start_op(6'd8, 1'b1, 68'h1234, nxt, nxt);
    tick(); tick();
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_busy: got %b want 1", Busy);
    end
    reset = 1'b0;
    #2;
    n_checks++;
    if ({WS, WC, U, UM, C, D, SqrtE, j1, jlast, Busy, ResultValid, EarlyExit} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0",
               {WS, WC, U, UM, C, D, SqrtE, j1, jlast, Busy, ResultValid, EarlyExit});
    end
    void'(sb_q.pop_front());
    reset = 1'b1;
    tick();
    nxt = rnd_res();
    start_op(6'd4, 1'b0, 68'h5678, nxt, nxt);
    wait_valid(20, lat);
    n_checks++;
    if (lat !== 5) begin
      n_fail++; $display("FAIL reset_restart_latency: got %0d want 5", lat);
    end
    exp = sb_q.pop_front();
    n_checks++;
    if (dut_res() !== exp) begin
      n_fail++; $display("FAIL reset_restart_result: got %h want %h", dut_res(), exp);
    end
    accept();
  endtask

  task automatic test_main();
    res_t nxt, exp;
    nxt = rnd_res();
    start_op(6'd8, 1'b1, 68'hA_5A5A_0F0F_3C3C_9999, nxt, nxt);
    n_checks++;
    if ({WS, WC, U, UM, C, D, SqrtE} !== {WSInit, 68'h0, UInit, UMInit, CInit, DIn, 1'b1}) begin
      n_fail++;
      $display("FAIL main_load: got %h want %h", {WS, WC, U, UM, C, D, SqrtE},
               {WSInit, 68'h0, UInit, UMInit, CInit, DIn, 1'b1});
    end
    for (int k = 1; k <= 9; k++) begin
      n_checks++;
      if ({j1, jlast, Busy, ResultValid} !== {k == 1, k == 8, k <= 8, k == 9}) begin
        n_fail++;
        $display("FAIL main_flags_c%0d: got %b want %b", k, {j1, jlast, Busy, ResultValid},
                 {k == 1, k == 8, k <= 8, k == 9});
      end
      if (k < 9) begin
        // a Start while busy must not disturb the run
        if (k == 3) begin Start = 1'b1; NumIter = 6'd1; end
        tick();
        Start = 1'b0;
      end
    end
    exp = sb_q.pop_front();
    // stage outputs change while DONE holds; registers must not follow
    {WSNext, WCNext, UNext, UMNext, CNext} = ~nxt;
    ResultReady = 1'b0;
    for (int h = 0; h < 3; h++) begin
      tick();
      n_checks++;
      if ({ResultValid, dut_res()} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL main_hold_%0d: got %h want %h", h, {ResultValid, dut_res()}, {1'b1, exp});
      end
    end
    accept();
    n_checks++;
    if ({Busy, ResultValid} !== 2'b00) begin
      n_fail++; $display("FAIL main_to_idle: got %b want 00", {Busy, ResultValid});
    end
  endtask

  task automatic test_min_iter();
    res_t nxt, exp;
    for (int n = 0; n < 2; n++) begin
      nxt = rnd_res();
      start_op(ITERW'(n), 1'b0, 68'h77, nxt, nxt);
      n_checks++;
      if ({j1, jlast, Busy, ResultValid} !== 4'b1110) begin
        n_fail++;
        $display("FAIL min_iter%0d_c1: got %b want 1110", n, {j1, jlast, Busy, ResultValid});
      end
      tick();
      exp = sb_q.pop_front();
      n_checks++;
      if ({Busy, ResultValid, dut_res()} !== {2'b01, exp}) begin
        n_fail++;
        $display("FAIL min_iter%0d_c2: got %h want %h", n, {Busy, ResultValid, dut_res()},
                 {2'b01, exp});
      end
      accept();
    end
  endtask

  task automatic test_divisor();
    logic [DIVB+3:0] dv [2];
    logic [DIVB+3:0] d2e;
    res_t nxt;
    dv[0] = 68'h0_0000_0000_0000_C000;
    dv[1] = 68'h8_0000_0000_0000_0001;
    for (int i = 0; i < 2; i++) begin
      nxt = rnd_res();
      start_op(6'd1, 1'b0, dv[i], nxt, nxt);
      d2e = dv[i] << 1;
      n_checks++;
      if ({D, DBar, D2, DBar2} !== {dv[i], ~dv[i], d2e, ~d2e}) begin
        n_fail++;
        $display("FAIL divisor_%0d: got %h want %h", i, {D, DBar, D2, DBar2},
                 {dv[i], ~dv[i], d2e, ~d2e});
      end
      tick();
      void'(sb_q.pop_front());
      accept();
    end
  endtask

  task automatic test_kill();
    res_t nxt, nxt2, exp;
    int   lat;
    nxt = rnd_res();
    start_op(6'd8, 1'b0, 68'h99, nxt, nxt);
    tick(); tick(); tick();
    Kill = 1'b1; Start = 1'b1; NumIter = 6'd3;
    tick();
    Kill = 1'b0; Start = 1'b0;
    void'(sb_q.pop_front());
    n_checks++;
    if ({Busy, ResultValid, j1, WS} !== {3'b000, nxt.ws}) begin
      n_fail++;
      $display("FAIL kill_idle: got %h want %h", {Busy, ResultValid, j1, WS}, {3'b000, nxt.ws});
    end
    nxt2 = rnd_res();
    start_op(6'd2, 1'b1, 68'h42, nxt2, nxt2);
    n_checks++;
    if ({Busy, j1} !== 2'b11) begin
      n_fail++; $display("FAIL kill_restart: got %b want 11", {Busy, j1});
    end
    wait_valid(20, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL kill_restart_latency: got %0d want 3", lat);
    end
    exp = sb_q.pop_front();
    n_checks++;
    if (dut_res() !== exp) begin
      n_fail++; $display("FAIL kill_restart_result: got %h want %h", dut_res(), exp);
    end
    accept();
  endtask

  task automatic test_zero_exit();
    res_t nxt, exp;
    int   lat, exp_lat;
    logic exp_early;
    nxt = rnd_res();
    exp = nxt;
`ifdef FDIVSQRT_ZERO_EXIT_EN
    exp.ws = '0; exp.wc = '0; exp_lat = 4; exp_early = 1'b1;
`else
    exp_lat = 9; exp_early = 1'b0;
`endif
    start_op(6'd8, 1'b0, 68'h3000, nxt, exp);
    tick(); tick();
    WSNext = '0; WCNext = '0;
    tick();
    WSNext = nxt.ws; WCNext = nxt.wc;
    wait_valid(20, lat);
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL zero_exit_latency: got %0d want %0d", lat, exp_lat);
    end
    n_checks++;
    if (EarlyExit !== exp_early) begin
      n_fail++; $display("FAIL zero_exit_flag: got %b want %b", EarlyExit, exp_early);
    end
    exp = sb_q.pop_front();
    n_checks++;
    if ({WS, WC, U} !== {exp.ws, exp.wc, exp.u}) begin
      n_fail++;
      $display("FAIL zero_exit_result: got %h want %h", {WS, WC, U}, {exp.ws, exp.wc, exp.u});
    end
    accept();
    nxt = rnd_res();
    start_op(6'd2, 1'b0, 68'h3000, nxt, nxt);
    n_checks++;
    if (EarlyExit !== 1'b0) begin
      n_fail++; $display("FAIL zero_exit_clear: got %b want 0", EarlyExit);
    end
    wait_valid(20, lat);
    exp = sb_q.pop_front();
    n_checks++;
    if ({lat, dut_res()} !== {32'sd3, exp}) begin
      n_fail++;
      $display("FAIL zero_exit_next_op: got %0d %h want 3 %h", lat, dut_res(), exp);
    end
    accept();
  endtask

  initial begin
    reset = 1'b0; Start = 1'b0; Kill = 1'b0; SqrtIn = 1'b0; ResultReady = 1'b0;
    NumIter = '0; WSInit = '0; DIn = '0; UInit = '0; UMInit = '0; CInit = '0;
    WSNext = '0; WCNext = '0; UNext = '0; UMNext = '0; CNext = '0;
    test_reset();
    test_main();
    test_min_iter();
    test_divisor();
    test_kill();
    test_zero_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fdivsqrt_iter_regs.md
Name: fdivsqrt_iter_regs

Overview:
- Iteration sequencer and state-register block directly upstream and downstream of the radix-4 divide/sqrt recurrence stage.
- Loads the initial residual, root/quotient, on-the-fly-converter and thermometer values from preprocessing.
- Drives the stage inputs each cycle, including the j1/jlast flags and the divisor multiples, and captures the stage's next-state outputs.
- Presents the final residual and root to postprocessing with a valid/ready handshake.

Parameters:
- DIVB, 64, fractional bits of residual/root datapath (residual Q4.DIVB, root U1.DIVB, C Q2.DIVB)
- ITERW, 6, width of iteration-count input and internal counter

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- Start  input  1  launch pulse; accepted only in IDLE
- Kill  input  1  abort (flush/trap); forces IDLE
- SqrtIn  input  1  operation select latched on Start (1=sqrt)
- NumIter  input  ITERW  radix-4 iterations to run; 0 treated as 1
- WSInit  input  DIVB+4  initial residual sum word
- DIn  input  DIVB+4  normalized divisor, latched on Start
- UInit, UMInit  input  DIVB+1  initial root/quotient and root-minus-ulp
- CInit  input  DIVB+2  initial thermometer code
- WSNext, WCNext  input  DIVB+4  from stage
- UNext, UMNext  input  DIVB+1  from stage
- CNext  input  DIVB+2  from stage
- WS, WC  output  DIVB+4  registered residual to stage and postproc
- U, UM  output  DIVB+1  registered root to stage and postproc
- C  output  DIVB+2  registered thermometer code to stage
- D, DBar, D2, DBar2  output  DIVB+4  D reg; ~D; D<<1; ~(D<<1)
- SqrtE  output  1  latched op select
- j1, jlast  output  1  first / final iteration flags
- Busy  output  1  high in ITER
- ResultValid  output  1  high in DONE
- ResultReady  input  1  postproc accepts result
- EarlyExit  output  1  see Optional Feature; 0 when compiled out

Behaviour:
- Reset (reset=0, async): state IDLE; WS, WC, U, UM, C, D, Cnt, LastIdx, SqrtE, EarlyExit all 0; Busy=0; ResultValid=0.
- States: IDLE, ITER, DONE.
- IDLE & Start & ~Kill:
  - WS<=WSInit, WC<=0, U<=UInit, UM<=UMInit, C<=CInit, D<=DIn, SqrtE<=SqrtIn.
  - Cnt<=0, LastIdx<=max(NumIter,1)-1.
  - Next state ITER.
- ITER, every cycle:
  - WS<=WSNext, WC<=WCNext, U<=UNext, UM<=UMNext, C<=CNext, Cnt<=Cnt+1.
  - j1 = (Cnt==0); jlast = (Cnt==LastIdx); both combinational from registers, 0 outside ITER.
  - When jlast: next state DONE; Cnt is not incremented.
  - NumIter=1 gives j1=jlast=1 in the same cycle.
- Latency: Start at cycle 0 → ITER cycles 1..N → ResultValid first high in cycle N+1.
- DONE:
  - All datapath registers hold; ResultValid=1.
  - ResultReady=1 → IDLE next cycle. ResultReady is ignored outside DONE.
- Start outside IDLE: ignored, no state change.
- Kill in any state: IDLE next cycle; datapath registers hold; ResultValid drops next cycle.
  - Kill wins over Start and over ResultReady when they occur in the same cycle.
- Counter: Cnt never wraps because LastIdx ≤ 2^ITERW−2. NumIter=2^ITERW−1 is legal and gives 2^ITERW−1 iterations.
- Divisor multiples are combinational from the D register. Bits shifted out of D2 are dropped.

Optional Feature:
- Macro: FDIVSQRT_ZERO_EXIT_EN.
- Defined:
  - In ITER, if ~jlast and WSNext==0 and WCNext==0 (exact bitwise zero), the Next values are captured as usual and the state goes to DONE instead of staying in ITER.
  - EarlyExit<=1 on that transition. EarlyExit is cleared on accepted Start and on reset.
  - U stays correct because the remaining digits would be 0. UM is undefined for postproc use when EarlyExit=1.
- Undefined: always runs LastIdx+1 iterations; EarlyExit tied 0.

Test Plan:
- Reset mid-ITER (cycle 3 of 8): all outputs 0 asynchronously; after release, Start with NumIter=4 → ResultValid first high 5 cycles after Start.
- Start, NumIter=8, stage model returning constant Next values: j1 high only in cycle 1, jlast only in cycle 8, Busy high for 8 cycles, ResultValid at cycle 9. Hold ResultReady=0 for 3 cycles → WS/U unchanged; ResultReady=1 → IDLE.
- NumIter=0 and NumIter=1: exactly one ITER cycle with j1=jlast=1; ResultValid at cycle 2.
- DIn=0x0000…0_C000 (DIVB=64): D2=DIn<<1, DBar=~DIn, DBar2=~(DIn<<1); check bitwise.
- Kill in cycle 4 of 8 with Start asserted simultaneously: IDLE next cycle, no ResultValid, Start ignored; a new Start one cycle later is accepted.
- With FDIVSQRT_ZERO_EXIT_EN, NumIter=8, WSNext=WCNext=0 in cycle 3: DONE at cycle 4, EarlyExit=1. Without the macro, the same stimulus completes at cycle 9 with EarlyExit=0.
